// File: rtl/bsg_mem_1rw_mask_rv_frontend.sv
// bsg_mem_1rw_mask_rv_frontend: ready/valid front-end for a 1rw bit-masked memory with zero-fill and a 2-entry response queue
module bsg_mem_1rw_mask_rv_frontend #(
  parameter int width_p = 8,
  parameter int els_p = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter bit init_p = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     init_done_o,
  output logic                     err_o
);
  typedef enum logic {INIT, RUN} state_e;
  localparam logic [addr_width_lp:0] els_lp = els_p[addr_width_lp:0];
  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);
  state_e r_state, w_state_n;
  logic [addr_width_lp-1:0] r_cnt, w_cnt_n;
  logic [1:0] r_count;
  logic r_rptr, r_wptr, r_inflight, r_inflight_oor, r_err;
  logic [width_p-1:0] r_q [2];
  logic w_run, w_ready, w_oor, w_accept, w_empty, w_pop, w_enq;
  logic [width_p-1:0] w_rdata;
  assign w_run    = r_state == RUN;
  assign w_ready  = w_run & (({1'b0, r_count} + {2'b0, r_inflight}) < 3'd2);
  assign w_oor    = {1'b0, addr_i} >= els_lp;
  assign w_accept = v_i & w_ready;
  assign w_empty  = r_count == 2'd0;
  assign w_rdata  = r_inflight_oor ? '0 : mem_data_i;
  assign w_pop    = yumi_i & ~w_empty;
  // a returning read bypasses the queue only when it is empty and taken at once
  assign w_enq    = r_inflight & ~(w_empty & yumi_i);
  assign ready_o     = reset_ni & w_ready;
  assign init_done_o = reset_ni & w_run;
  assign v_o         = reset_ni & (~w_empty | r_inflight);
  assign data_o      = w_empty ? w_rdata : r_q[r_rptr];
  assign err_o       = r_err;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    if (!w_run) begin
      w_cnt_n = r_cnt + 1'b1;
      w_state_n = (r_cnt == last_lp) ? RUN : INIT;
    end
  end
  always_comb begin
    mem_v_o = 1'b0;
    mem_w_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_w_mask_o = '0;
    if (reset_ni && !w_run) begin
      mem_v_o = 1'b1;
      mem_w_o = 1'b1;
      mem_addr_o = r_cnt;
      mem_w_mask_o = '1;
    end else if (reset_ni) begin
      mem_v_o = w_accept & ~w_oor;
      mem_w_o = mem_v_o & w_i;
      mem_addr_o = addr_i;
      mem_data_o = data_i;
      mem_w_mask_o = mem_v_o ? w_mask_i : '0;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= init_p ? INIT : RUN;
      r_cnt <= '0;
      r_count <= '0;
      r_rptr <= 1'b0;
      r_wptr <= 1'b0;
      r_inflight <= 1'b0;
      r_inflight_oor <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_inflight <= w_accept & ~w_i;
      r_inflight_oor <= w_accept & ~w_i & w_oor;
      r_err <= r_err | (w_accept & w_oor);
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_pop};
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_enq) r_q[r_wptr] <= w_rdata;
  end
endmodule

// File: tb/tb_bsg_mem_1rw_mask_rv_frontend.sv
// tb_bsg_mem_1rw_mask_rv_frontend: directed bench with a behavioural masked memory behind the front-end
module tb_bsg_mem_1rw_mask_rv_frontend;
  logic clk, reset_ni, v_i, ready_o, w_i, v_o, yumi_i, mem_v_o, mem_w_o, init_done_o, err_o;
  logic [4:0] addr_i, mem_addr_o;
  logic [7:0] data_i, w_mask_i, data_o, mem_data_o, mem_w_mask_o, mem_data_i;
  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  bsg_mem_1rw_mask_rv_frontend #(.width_p(8), .els_p(16), .addr_width_lp(5), .init_p(1'b1)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i),
    .init_done_o(init_done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory starts with a non-zero pattern so the zero-fill is observable
  always @(posedge clk) begin
    if (!reset_ni) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h5A;
    end else if (mem_v_o && mem_w_o) begin
      mem[mem_addr_o[3:0]] <= (mem[mem_addr_o[3:0]] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
    end else if (mem_v_o) begin
      mem_data_i <= mem[mem_addr_o[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [7:0] d,
                       input logic [7:0] m, input logic y);
    @(negedge clk);
    v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m; yumi_i = y;
    #1;
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 1);
  endfunction

  initial begin
    reset_ni = 1'b0; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; w_mask_i = '0; yumi_i = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_ready", ready_o, 0);
    check("rst_mem_v", mem_v_o, 0);
    check("rst_v_o", v_o, 0);
    check("rst_err", err_o, 0);
    check("rst_done", init_done_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("init1_addr", mem_addr_o, i);
      check("init1_v", mem_v_o, 1);
      @(negedge clk);
    end
    reset_ni = 1'b0;
    #1;
    check("midrst_mem_v", mem_v_o, 0);
    check("midrst_ready", ready_o, 0);
    check("midrst_v_o", v_o, 0);
    check("midrst_err", err_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("init_v", mem_v_o, 1);
      check("init_w", mem_w_o, 1);
      check("init_addr", mem_addr_o, i);
      check("init_data", mem_data_o, 0);
      check("init_mask", mem_w_mask_o, 8'hFF);
      check("init_ready", ready_o, 0);
      check("init_done_early", init_done_o, 0);
      @(negedge clk);
    end
    #1;
    check("run_ready", ready_o, 1);
    check("run_done", init_done_o, 1);
    check("run_mem_v", mem_v_o, 0);

    drive(1, 0, 5, 0, 0, 0);
    check("rd5_mem_v", mem_v_o, 1);
    check("rd5_mem_w", mem_w_o, 0);
    check("rd5_addr", mem_addr_o, 5);
    drive(0, 0, 0, 0, 0, 1);
    check("rd5_v_o", v_o, 1);
    check("rd5_data", data_o, 0);

    drive(1, 1, 3, 8'hAB, 8'h0F, 0);
    check("wr3_mem_w", mem_w_o, 1);
    check("wr3_mask", mem_w_mask_o, 8'h0F);
    check("wr3_data", mem_data_o, 8'hAB);
    drive(1, 0, 3, 0, 0, 0);
    check("wr_no_resp", v_o, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("rd3_v_o", v_o, 1);
    check("rd3_data", data_o, 8'h0B);

    drive(1, 1, 1, 8'h11, 8'hFF, 0);
    drive(1, 1, 2, 8'h22, 8'hFF, 0);
    drive(1, 0, 1, 0, 0, 0);
    check("bp_rd1_ready", ready_o, 1);
    drive(1, 0, 2, 0, 0, 0);
    check("bp_rd2_ready", ready_o, 1);
    check("bp_rd2_v_o", v_o, 1);
    check("bp_rd2_data", data_o, 8'h11);
    drive(1, 0, 3, 0, 0, 0);
    check("bp_rd3_ready", ready_o, 0);
    check("bp_rd3_mem_v", mem_v_o, 0);
    check("bp_rd3_data", data_o, 8'h11);
    drive(0, 0, 0, 0, 0, 1);
    check("bp_full_ready", ready_o, 0);
    check("bp_pop1_v_o", v_o, 1);
    check("bp_pop1_data", data_o, 8'h11);
    drive(0, 0, 0, 0, 0, 1);
    check("bp_pop2_v_o", v_o, 1);
    check("bp_pop2_data", data_o, 8'h22);
    check("bp_ready_back", ready_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("bp_drained", v_o, 0);

    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 5'(a), pat(a), 8'hFF, 0);
      check("fill_mem_v", mem_v_o, 1);
    end
    for (int k = 0; k <= 100; k++) begin
      drive(k < 100, 0, 5'(k % 16), 0, 0, 1);
      if (k < 100) check("stream_ready", ready_o, 1);
      if (k > 0) begin
        check("stream_v_o", v_o, 1);
        check("stream_data", data_o, pat((k - 1) % 16));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    check("stream_idle", v_o, 0);

    drive(1, 0, 20, 0, 0, 0);
    check("oor_mem_v", mem_v_o, 0);
    check("oor_ready", ready_o, 1);
    check("oor_err_before", err_o, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("oor_v_o", v_o, 1);
    check("oor_data", data_o, 0);
    check("oor_err", err_o, 1);
    drive(1, 1, 20, 8'hFF, 8'hFF, 0);
    check("oor_wr_mem_v", mem_v_o, 0);
    check("oor_wr_mem_w", mem_w_o, 0);
    check("oor_wr_mask", mem_w_mask_o, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("oor_wr_no_resp", v_o, 0);
    check("oor_err_sticky", err_o, 1);
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    check("final_rst_err", err_o, 0);
    check("final_rst_v_o", v_o, 0);
    check("final_rst_done", init_done_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
